mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port memory (sync write, combinational read when read_en) between
//  the instruction-fetch port (I) and the load/store port (D) of the RISC-V core.
//  Each port runs a req/ack handshake. The arbiter latches the winning request and
//  drives the memory for one cycle. It returns registered read data with a one-cycle ack.
//  Data port has priority; a streak limit bounds instruction-fetch starvation.
// PARAMETERS
//  A_BITS        10    address width, word addressed
//  D_BITS        32    data width
//  MEMSIZE       1024  words present; addresses >= MEMSIZE are errors
//  MAX_D_STREAK  4     max consecutive D grants while i_req is pending (>=1)
// PORTS
//  clk           in   1       clock; all state changes on posedge
//  reset         in   1       synchronous, active-high reset
//  i_req         in   1       fetch request; held with i_addr stable until i_ack
//  i_addr        in   A_BITS  fetch address
//  i_ack         out  1       one-cycle pulse: fetch complete, i_rdata/i_err valid
//  i_rdata       out  D_BITS  registered fetch data
//  i_err         out  1       valid with i_ack: address out of range
//  d_req         in   1       load/store request; held with d_* stable until d_ack
//  d_we          in   1       1 = store, 0 = load
//  d_addr        in   A_BITS  load/store address
//  d_wdata       in   D_BITS  store data
//  d_ack         out  1       one-cycle pulse: access complete
//  d_rdata       out  D_BITS  registered load data (holds last value on store)
//  d_err         out  1       valid with d_ack: address out of range
//  mem_addr      out  A_BITS  memory address
//  mem_wdata     out  D_BITS  memory write data
//  mem_read_en   out  1       memory read enable
//  mem_write_en  out  1       memory write enable
//  mem_rdata     in   D_BITS  memory read data (combinational)
//  busy          out  1       state != IDLE
// BEHAVIOUR
//  - States: IDLE -> ACCESS -> RESP -> IDLE. Each access takes 3 cycles, IDLE to IDLE.
//  - IDLE: if no req, stay. Otherwise pick the winner and latch its addr, we and wdata
//    plus the owner bit, then go to ACCESS. I requests have we=0.
//  - Winner: only one req -> that port. Both -> D, unless streak==MAX_D_STREAK -> I.
//  - Streak counter: +1 on each D grant while i_req=1. Cleared on any I grant and on
//    any D grant with i_req=0. Saturates at MAX_D_STREAK.
//  - ACCESS: drive mem_addr/mem_wdata from the latched values.
//    mem_read_en  = !we_l && in_range.
//    mem_write_en =  we_l && in_range && !reset.
//    At the closing edge the store commits, or mem_rdata is captured into the owner's
//    rdata. Out-of-range: no enable asserted, rdata unchanged, err flag latched. Go RESP.
//  - RESP: owner's ack=1 and err valid for exactly one cycle, then IDLE.
//  - Outside ACCESS: mem_addr=0, mem_wdata=0, both enables 0.
//  - Latency: req high in IDLE cycle 0 -> ack in cycle 2.
//  - Requester drops req (or presents a new request) at the edge ending its ack cycle.
//    A req still high in the following IDLE is treated as a new request.
//  - Inputs are ignored outside IDLE; changing them mid-access has no effect.
//  - Reset value of every output is 0. State=IDLE, streak=0, latched regs=0.
//  - Reset mid-operation: the in-flight access is abandoned; no ack is issued.
//    A write is blocked even if reset is asserted in the ACCESS cycle.
//  - in_range = (latched addr < MEMSIZE). When MEMSIZE == 2**A_BITS it is always 1.
// TESTING
//  1. Load: mem[5]=32'hDEADBEEF; d_req, we=0, addr=5 in cycle 0 -> mem_read_en in
//     cycle 1, d_ack with d_rdata=DEADBEEF in cycle 2, d_err=0.
//  2. Store then fetch: d store 32'h12345678 to addr 7, then i_req addr 7 ->
//     mem_write_en in one cycle only, i_rdata=12345678 with i_ack.
//  3. Contention, MAX_D_STREAK=4: i_req and d_req both held high -> grant order
//     D,D,D,D,I,D,D,D,D,I..., one ack per 3 cycles, never both acks in one cycle.
//  4. MEMSIZE=512: d store to addr 600 -> no mem_write_en, d_ack with d_err=1,
//     mem[88] untouched.
//  5. Reset asserted in the ACCESS cycle of a store -> mem_write_en=0, no d_ack,
//     all outputs 0 next cycle, then a fresh request completes normally.
//  6. Idle: no req for 10 cycles -> busy=0, all enables 0, acks 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the instruction-fetch (I) and load/store (D) ports.
// Each access runs IDLE -> ACCESS -> RESP. D has priority, and a streak limit bounds I starvation.
module mem_arbiter #(
  parameter int A_BITS       = 10,
  parameter int D_BITS       = 32,
  parameter int MEMSIZE      = 1024,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [A_BITS-1:0] i_addr,
  output logic              i_ack,
  output logic [D_BITS-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [A_BITS-1:0] d_addr,
  input  logic [D_BITS-1:0] d_wdata,
  output logic              d_ack,
  output logic [D_BITS-1:0] d_rdata,
  output logic              d_err,
  output logic [A_BITS-1:0] mem_addr,
  output logic [D_BITS-1:0] mem_wdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [D_BITS-1:0] mem_rdata,
  output logic              busy
);

  // state  | meaning
  // IDLE   | waiting for a request; the winner is latched on exit
  // ACCESS | memory driven from the latched request for one cycle
  // RESP   | the owner's ack and err are presented for one cycle
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam int              SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [A_BITS:0] MEM_LIM    = (A_BITS + 1)'(MEMSIZE);

  logic [1:0]        state;
  logic [SW-1:0]     streak;
  logic              owner_d;
  logic              we_l;
  logic [A_BITS-1:0] addr_l;
  logic [D_BITS-1:0] wdata_l;
  logic              in_range;
  logic              grant_d;
  logic              in_access;

  // The limit compare is one bit wider so that a full-size memory is never out of range.
  assign in_range  = {1'b0, addr_l} < MEM_LIM;
  assign grant_d   = d_req && !(i_req && streak == STREAK_MAX);
  assign in_access = state == ACCESS;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      streak  <= '0;
      owner_d <= 1'b0;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      i_rdata <= '0;
      i_err   <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            owner_d <= grant_d;
            addr_l  <= grant_d ? d_addr : i_addr;
            we_l    <= grant_d && d_we;
            wdata_l <= grant_d ? d_wdata : '0;
            if (grant_d && i_req)
              streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
            else
              streak <= '0;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (owner_d) begin
            d_err <= !in_range;
            if (!we_l && in_range) d_rdata <= mem_rdata;
          end else begin
            i_err <= !in_range;
            if (in_range) i_rdata <= mem_rdata;
          end
          state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The write enable also looks at reset, so a reset in the ACCESS cycle blocks the store.
  assign mem_addr     = in_access ? addr_l : '0;
  assign mem_wdata    = in_access ? wdata_l : '0;
  assign mem_read_en  = in_access && !we_l && in_range;
  assign mem_write_en = in_access && we_l && in_range && !reset;
  assign i_ack        = (state == RESP) && !owner_d;
  assign d_ack        = (state == RESP) && owner_d;
  assign busy         = state != IDLE;

endmodule
